// File: rtl/accumulator_pkg.sv
// Shared types and constants for the column accumulator bank.
// Saturation limits are computed at up to 64 bits and sliced down to ACC_BW by users.
package accumulator_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        REDUCE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam logic MODE_COLUMN = 1'b0;
    localparam logic MODE_REDUCE = 1'b1;

    localparam int MAX_ACC_BW = 64;

    function automatic logic [MAX_ACC_BW-1:0] satMax(input int unsigned w);
        return (MAX_ACC_BW'(1) << (w - 1)) - MAX_ACC_BW'(1);
    endfunction

    function automatic logic [MAX_ACC_BW-1:0] satMin(input int unsigned w);
        return MAX_ACC_BW'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Signed ACC_BW adder with optional saturation; ovf_o flags any unrepresentable sum,
// regardless of whether the result is clamped or wrapped.
module sat_adder
    import accumulator_pkg::*;
#(
    parameter int ACC_BW = 32,
    parameter int SAT    = 1
) (
    input  logic signed [ACC_BW-1:0] a_i,
    input  logic signed [ACC_BW-1:0] b_i,
    output logic signed [ACC_BW-1:0] sum_o,
    output logic                     ovf_o
);

    localparam logic [ACC_BW-1:0] MAX_V = ACC_BW'(satMax(ACC_BW));
    localparam logic [ACC_BW-1:0] MIN_V = ACC_BW'(satMin(ACC_BW));

    logic [ACC_BW:0] fullSum;

    assign fullSum = {a_i[ACC_BW-1], a_i} + {b_i[ACC_BW-1], b_i};
    assign ovf_o   = fullSum[ACC_BW] ^ fullSum[ACC_BW-1];

    // The extra sign bit tells which rail an overflowing sum escaped through.
    always_comb begin
        sum_o = fullSum[ACC_BW-1:0];
        if ((SAT != 0) && ovf_o) begin
            sum_o = fullSum[ACC_BW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/accumulator_bank.sv
// Column accumulator bank: accumulates K-tile beats per column, then drains either
// every column or one reduced word to the output buffer under valid/ready.
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ACC_BW      = 32,
    parameter int ADDR_W      = 4,
    parameter int SAT         = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            acc_clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] in_data,
    input  logic                            in_last,
    input  logic [ADDR_W-1:0]               op_buffer_address,
    input  logic                            mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_BW-1:0]               output_data,
    output logic [ADDR_W-1:0]               output_buffer_addr,
    output logic                            busy,
    output logic                            overflow
);

    localparam int IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);

    state_e                   state_q, state_d;
    logic signed [ACC_BW-1:0] acc_q [ARR_SIZE];
    logic signed [ACC_BW-1:0] acc_d [ARR_SIZE];
    logic                     overflow_q, overflow_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_BW-1:0]        data_q, data_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic                     mode_q, mode_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    logic signed [ACC_BW-1:0] colA     [ARR_SIZE];
    logic signed [ACC_BW-1:0] colB     [ARR_SIZE];
    logic signed [ACC_BW-1:0] colSum   [ARR_SIZE];
    logic signed [ACC_BW-1:0] chainSum [ARR_SIZE];
    logic [ARR_SIZE-1:0]      colOvf;
    logic [ARR_SIZE-1:0]      chainOvf;

    logic             clearEff;
    logic             beat;
    logic             outXfer;
    logic [IDX_W-1:0] nextIdx;

    assign in_ready           = (state_q == ACCUM);
    assign busy               = (state_q != ACCUM);
    assign out_valid          = out_valid_q;
    assign output_data        = data_q;
    assign output_buffer_addr = addr_q;
    assign overflow           = overflow_q;

    assign clearEff = acc_clear && (state_q == ACCUM);
    assign beat     = in_valid && in_ready;
    assign outXfer  = out_valid_q && out_ready;
    assign nextIdx  = idx_q + IDX_W'(1);

    // Clear zeroes the adder's accumulator operand so a colliding beat lands on zero.
    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_col
        assign colA[k] = clearEff ? '0 : acc_q[k];
        assign colB[k] = ACC_BW'(signed'(in_data[k*VERTICAL_BW +: VERTICAL_BW]));
        sat_adder #(.ACC_BW(ACC_BW), .SAT(SAT)) u_col (
            .a_i  (colA[k]),
            .b_i  (colB[k]),
            .sum_o(colSum[k]),
            .ovf_o(colOvf[k])
        );
    end

    assign chainSum[0] = acc_q[0];
    assign chainOvf[0] = 1'b0;

    for (genvar k = 1; k < ARR_SIZE; k++) begin : g_chain
        sat_adder #(.ACC_BW(ACC_BW), .SAT(SAT)) u_red (
            .a_i  (chainSum[k-1]),
            .b_i  (acc_q[k]),
            .sum_o(chainSum[k]),
            .ovf_o(chainOvf[k])
        );
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        addr_d      = addr_q;
        base_d      = base_q;
        mode_d      = mode_q;
        idx_d       = idx_q;

        unique case (state_q)
            ACCUM: begin
                if (clearEff) begin
                    for (int k = 0; k < ARR_SIZE; k++) acc_d[k] = '0;
                    overflow_d = 1'b0;
                end
                if (beat) begin
                    for (int k = 0; k < ARR_SIZE; k++) acc_d[k] = colSum[k];
                    overflow_d = (overflow_q && !clearEff) || (|colOvf);
                    if (in_last) begin
                        base_d = op_buffer_address;
                        mode_d = mode;
                        idx_d  = '0;
                        // Column mode presents word 0 straight from the adder to save a cycle.
                        if (mode == MODE_COLUMN) begin
                            state_d     = DRAIN;
                            out_valid_d = 1'b1;
                            data_d      = colSum[0];
                            addr_d      = op_buffer_address;
                        end else begin
                            state_d = REDUCE;
                        end
                    end
                end
            end
            REDUCE: begin
                data_d      = chainSum[ARR_SIZE-1];
                addr_d      = base_q;
                overflow_d  = overflow_q || (|chainOvf);
                out_valid_d = 1'b1;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (outXfer) begin
                    if ((mode_q == MODE_REDUCE) || (idx_q == LAST_IDX)) begin
                        for (int k = 0; k < ARR_SIZE; k++) acc_d[k] = '0;
                        out_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end else begin
                        idx_d  = nextIdx;
                        data_d = acc_q[nextIdx];
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            for (int k = 0; k < ARR_SIZE; k++) acc_q[k] <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            mode_q      <= MODE_COLUMN;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            for (int k = 0; k < ARR_SIZE; k++) acc_q[k] <= acc_d[k];
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
        end
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: a scoreboard queue holds expected drain words,
// and a second instance built with SAT=0 covers the wrapping adder.
module tb_accumulator_bank;
    import accumulator_pkg::*;

    localparam int ARR = 4;
    localparam int VW  = 32;
    localparam int AW  = 32;
    localparam int ADW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               acc_clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               mode = 1'b0;
    logic               out_ready = 1'b0;
    logic [ARR*VW-1:0]  in_data = '0;
    logic [ADW-1:0]     op_buffer_address = '0;

    logic               in_ready, out_valid, busy, overflow;
    logic [AW-1:0]      output_data;
    logic [ADW-1:0]     output_buffer_addr;
    logic               in_ready_w, out_valid_w, busy_w, overflow_w;
    logic [AW-1:0]      output_data_w;
    logic [ADW-1:0]     output_buffer_addr_w;

    typedef struct packed {
        logic [AW-1:0]  data;
        logic [ADW-1:0] addr;
    } word_t;

    word_t sbQ[$];
    int    passCount = 0;
    int    failCount = 0;
    int    checkCount = 0;

    accumulator_bank #(.ARR_SIZE(ARR), .VERTICAL_BW(VW), .ACC_BW(AW), .ADDR_W(ADW), .SAT(1)) dut (
        .clk(clk), .rst(rst), .acc_clear(acc_clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .op_buffer_address(op_buffer_address), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
        .output_buffer_addr(output_buffer_addr), .busy(busy), .overflow(overflow)
    );

    accumulator_bank #(.ARR_SIZE(ARR), .VERTICAL_BW(VW), .ACC_BW(AW), .ADDR_W(ADW), .SAT(0)) dutWrap (
        .clk(clk), .rst(rst), .acc_clear(acc_clear), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_last(in_last), .op_buffer_address(op_buffer_address), .mode(mode),
        .out_valid(out_valid_w), .out_ready(out_ready), .output_data(output_data_w),
        .output_buffer_addr(output_buffer_addr_w), .busy(busy_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ARR*VW-1:0] pack4(input logic [VW-1:0] c0, input logic [VW-1:0] c1,
                                                input logic [VW-1:0] c2, input logic [VW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic applyStimulus(input logic [ARR*VW-1:0] data, input logic last, input logic m,
                                 input logic [ADW-1:0] addr, input logic clr);
        checkOutput("in_ready_at_beat", in_ready, 1'b1);
        in_data           = data;
        in_last           = last;
        mode              = m;
        op_buffer_address = addr;
        acc_clear         = clr;
        in_valid          = 1'b1;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        acc_clear = 1'b0;
    endtask

    task automatic expectColumns(input logic [ARR*VW-1:0] data, input logic [ADW-1:0] base);
        for (int k = 0; k < ARR; k++) begin
            sbQ.push_back('{data: data[k*VW +: VW], addr: base + ADW'(k)});
        end
    endtask

    task automatic expectReduce(input logic [AW-1:0] value, input logic [ADW-1:0] addr);
        sbQ.push_back('{data: value, addr: addr});
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sbQ.size() != 0; i++) step();
        checkOutput("drain_done", sbQ.size(), 0);
        checkOutput("in_ready_after_drain", in_ready, 1'b1);
    endtask

    // Every presented word must match the queue head, which also catches data moving while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checkOutput("sb_has_word", sbQ.size() != 0, 1'b1);
            if (sbQ.size() != 0) begin
                checkOutput("out_data", output_data, sbQ[0].data);
                checkOutput("out_addr", output_buffer_addr, sbQ[0].addr);
                if (out_ready) void'(sbQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #12;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_output_data", output_data, 0);
        checkOutput("rst_output_addr", output_buffer_addr, 0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Per-column single beat: words on four consecutive cycles, ready again after.
        out_ready = 1'b1;
        expectColumns(pack4(1, 2, 3, 4), 4'h2);
        applyStimulus(pack4(1, 2, 3, 4), 1'b1, MODE_COLUMN, 4'h2, 1'b0);
        checkOutput("col_first_valid", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("col_valid_streak", out_valid, 1'b1);
            checkOutput("col_in_ready_low", in_ready, 1'b0);
        end
        waitDrain(10);

        // Multi-beat reduce: 4 columns x 3 beats summed into one word two cycles later.
        expectReduce(32'd300, 4'h7);
        applyStimulus(pack4(10, 20, 30, 40), 1'b0, MODE_REDUCE, 4'h7, 1'b0);
        applyStimulus(pack4(10, 20, 30, 40), 1'b0, MODE_REDUCE, 4'h7, 1'b0);
        applyStimulus(pack4(10, 20, 30, 40), 1'b1, MODE_REDUCE, 4'h7, 1'b0);
        checkOutput("red_not_yet_valid", out_valid, 1'b0);
        checkOutput("red_busy", busy, 1'b1);
        step();
        checkOutput("red_valid", out_valid, 1'b1);
        waitDrain(10);
        expectColumns(pack4(1, 1, 1, 1), 4'h0);
        applyStimulus(pack4(1, 1, 1, 1), 1'b1, MODE_COLUMN, 4'h0, 1'b0);
        waitDrain(10);

        // Backpressure with address wrap past 4'hF.
        out_ready = 1'b0;
        expectColumns(pack4(7, 8, 9, 10), 4'hE);
        applyStimulus(pack4(7, 8, 9, 10), 1'b1, MODE_COLUMN, 4'hE, 1'b0);
        for (int i = 0; i < 40 && sbQ.size() != 0; i++) begin
            out_ready = (i < 3) ? 1'b0 : i[0];
            step();
        end
        checkOutput("bp_drain_done", sbQ.size(), 0);
        checkOutput("bp_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        // Saturation versus wrap on column 0.
        applyStimulus(pack4(32'h7FFF_FFF0, 0, 0, 0), 1'b0, MODE_COLUMN, 4'h0, 1'b0);
        checkOutput("sat_no_ovf_yet", overflow, 1'b0);
        expectColumns(pack4(32'h7FFF_FFFF, 0, 0, 0), 4'h0);
        applyStimulus(pack4(32'h0000_0020, 0, 0, 0), 1'b1, MODE_COLUMN, 4'h0, 1'b0);
        checkOutput("sat_overflow", overflow, 1'b1);
        checkOutput("wrap_overflow", overflow_w, 1'b1);
        checkOutput("wrap_valid", out_valid_w, 1'b1);
        checkOutput("wrap_word0", output_data_w, 32'h8000_0010);
        waitDrain(10);
        checkOutput("sat_ovf_sticky", overflow, 1'b1);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        checkOutput("sat_ovf_cleared", overflow, 1'b0);
        checkOutput("wrap_ovf_cleared", overflow_w, 1'b0);

        // Clear colliding with a beat, then clear held through a drain.
        applyStimulus(pack4(5, 5, 5, 5), 1'b0, MODE_COLUMN, 4'h0, 1'b0);
        expectColumns(pack4(1, 2, 3, 4), 4'h0);
        applyStimulus(pack4(1, 2, 3, 4), 1'b1, MODE_COLUMN, 4'h0, 1'b1);
        waitDrain(10);
        expectColumns(pack4(6, 7, 8, 9), 4'h8);
        applyStimulus(pack4(6, 7, 8, 9), 1'b1, MODE_COLUMN, 4'h8, 1'b0);
        acc_clear = 1'b1;
        waitDrain(10);
        acc_clear = 1'b0;

        // Async reset between drain words 1 and 2.
        expectColumns(pack4(11, 12, 13, 14), 4'h3);
        applyStimulus(pack4(11, 12, 13, 14), 1'b1, MODE_COLUMN, 4'h3, 1'b0);
        step();
        checkOutput("ar_word1_present", output_data, 32'd12);
        rst = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("ar_valid_dropped", out_valid, 1'b0);
        checkOutput("ar_busy_low", busy, 1'b0);
        checkOutput("ar_data_zero", output_data, 0);
        checkOutput("ar_addr_zero", output_buffer_addr, 0);
        step();
        step();
        rst = 1'b0;
        step();
        checkOutput("ar_in_ready", in_ready, 1'b1);
        checkOutput("ar_overflow", overflow, 1'b0);
        expectReduce(32'd90, 4'h9);
        applyStimulus(pack4(21, 22, 23, 24), 1'b1, MODE_REDUCE, 4'h9, 1'b0);
        waitDrain(10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
